// File: rtl/core_pkg.sv
// Shared definitions for the memory-access stage: LSU operation codes, FSM states
// and small decode helpers used by the stage and its alignment unit.
package core_pkg;

   typedef enum logic [3:0] {
      LSU_NONE  = 4'd0,
      LSU_LD_B  = 4'd1,
      LSU_LD_H  = 4'd2,
      LSU_LD_W  = 4'd3,
      LSU_LD_BU = 4'd4,
      LSU_LD_HU = 4'd5,
      LSU_ST_B  = 4'd6,
      LSU_ST_H  = 4'd7,
      LSU_ST_W  = 4'd8
   } lsu_op_e;

   typedef enum logic [1:0] {
      MA_IDLE = 2'd0,
      MA_REQ  = 2'd1,
      MA_WAIT = 2'd2,
      MA_HOLD = 2'd3
   } ma_state_e;

   // Unassigned encodings collapse to LSU_NONE so they behave like ALU ops.
   function automatic lsu_op_e lsu_decode(input logic [3:0] i_raw);
      lsu_op_e w_op;
      case (i_raw)
         4'd1:    w_op = LSU_LD_B;
         4'd2:    w_op = LSU_LD_H;
         4'd3:    w_op = LSU_LD_W;
         4'd4:    w_op = LSU_LD_BU;
         4'd5:    w_op = LSU_LD_HU;
         4'd6:    w_op = LSU_ST_B;
         4'd7:    w_op = LSU_ST_H;
         4'd8:    w_op = LSU_ST_W;
         default: w_op = LSU_NONE;
      endcase
      return w_op;
   endfunction

   function automatic logic lsu_is_store(input lsu_op_e i_op);
      logic w_st;
      case (i_op)
         LSU_ST_B, LSU_ST_H, LSU_ST_W: w_st = 1'b1;
         default:                      w_st = 1'b0;
      endcase
      return w_st;
   endfunction

   function automatic logic lsu_misaligned(input lsu_op_e i_op, input logic [1:0] i_lo);
      logic w_mis;
      case (i_op)
         LSU_LD_H, LSU_LD_HU, LSU_ST_H: w_mis = i_lo[0];
         LSU_LD_W, LSU_ST_W:            w_mis = (i_lo != 2'b00);
         default:                       w_mis = 1'b0;
      endcase
      return w_mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the data bus: places store data/strobes on the lanes selected
// by the address, and extracts plus sign/zero-extends load data from the read word.
module lsu_align
   import core_pkg::*;
(
   input  lsu_op_e     i_st_op,
   input  logic [1:0]  i_st_addr_lo,
   input  logic [31:0] i_st_data,
   input  lsu_op_e     i_ld_op,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Store lane placement: data is replicated so every strobed lane carries it.
   always_comb begin
      o_wdata = 32'd0;
      o_wstrb = 4'b0000;
      case (i_st_op)
         LSU_ST_B: begin
            o_wdata = {4{i_st_data[7:0]}};
            o_wstrb = 4'b0001 << i_st_addr_lo;
         end
         LSU_ST_H: begin
            o_wdata = {2{i_st_data[15:0]}};
            o_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         LSU_ST_W: begin
            o_wdata = i_st_data;
            o_wstrb = 4'b1111;
         end
         default: begin
            o_wdata = 32'd0;
            o_wstrb = 4'b0000;
         end
      endcase
   end

   assign w_byte = i_rdata[{i_ld_addr_lo, 3'b000} +: 8];
   assign w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

   // Load extraction with sign or zero extension.
   always_comb begin
      o_ld_data = 32'd0;
      case (i_ld_op)
         LSU_LD_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
         LSU_LD_BU: o_ld_data = {24'd0, w_byte};
         LSU_LD_H:  o_ld_data = {{16{w_half[15]}}, w_half};
         LSU_LD_HU: o_ld_data = {16'd0, w_half};
         LSU_LD_W:  o_ld_data = i_rdata;
         default:   o_ld_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: passes ALU results through in one cycle and runs
// aligned loads/stores over a request/grant/rvalid data bus with a registered output slot.
module memory_access
   import core_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [31:0]           ex_pc,
   input  logic [31:0]           ex_inst,
   input  logic [DATA_WIDTH-1:0] ex_result,
   input  logic [3:0]            ex_lsu_op,
   input  logic [DATA_WIDTH-1:0] ex_lsu_data,
   input  logic                  ex_rd_wr_en,
   input  logic [4:0]            ex_rd_wr_addr,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [31:0]           dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [3:0]            dmem_wstrb,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [31:0]           mem_pc,
   output logic [31:0]           mem_inst,
   output logic                  mem_rd_wr_en,
   output logic [4:0]            mem_rd_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_rd_wr_data,
   output logic                  mem_ale
);

   ma_state_e   r_state;
   lsu_op_e     r_ld_op;
   logic [1:0]  r_ld_lo;
   logic        r_dmem_req;
   logic        r_dmem_we;
   logic [31:0] r_dmem_addr;
   logic [31:0] r_dmem_wdata;
   logic [3:0]  r_dmem_wstrb;
   logic        r_mem_valid;
   logic [31:0] r_mem_pc;
   logic [31:0] r_mem_inst;
   logic        r_mem_rd_wr_en;
   logic [4:0]  r_mem_rd_wr_addr;
   logic [31:0] r_mem_rd_wr_data;
   logic        r_mem_ale;

   lsu_op_e     w_op;
   logic [1:0]  w_lo;
   logic        w_store;
   logic        w_misal;
   logic        w_ex_ready;
   logic        w_fire;
   logic [31:0] w_st_wdata;
   logic [3:0]  w_st_wstrb;
   logic [31:0] w_ld_data;

   assign w_op       = lsu_decode(ex_lsu_op);
   assign w_lo       = ex_result[1:0];
   assign w_store    = lsu_is_store(w_op);
   assign w_misal    = lsu_misaligned(w_op, w_lo);
   assign w_ex_ready = (r_state == MA_IDLE) && (!r_mem_valid || mem_ready);
   assign w_fire     = ex_valid && w_ex_ready;

   lsu_align u_lsu_align (
      .i_st_op      (w_op),
      .i_st_addr_lo (w_lo),
      .i_st_data    (ex_lsu_data),
      .i_ld_op      (r_ld_op),
      .i_ld_addr_lo (r_ld_lo),
      .i_rdata      (dmem_rdata),
      .o_wdata      (w_st_wdata),
      .o_wstrb      (w_st_wstrb),
      .o_ld_data    (w_ld_data)
   );

   // Stage FSM and all registered outputs; the output slot is only rewritten when
   // it is empty or being accepted in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= MA_IDLE;
         r_ld_op          <= LSU_NONE;
         r_ld_lo          <= 2'b00;
         r_dmem_req       <= 1'b0;
         r_dmem_we        <= 1'b0;
         r_dmem_addr      <= 32'd0;
         r_dmem_wdata     <= 32'd0;
         r_dmem_wstrb     <= 4'b0000;
         r_mem_valid      <= 1'b0;
         r_mem_pc         <= 32'd0;
         r_mem_inst       <= 32'd0;
         r_mem_rd_wr_en   <= 1'b0;
         r_mem_rd_wr_addr <= 5'd0;
         r_mem_rd_wr_data <= 32'd0;
         r_mem_ale        <= 1'b0;
      end else begin
         case (r_state)
            MA_IDLE: begin
               if (r_mem_valid && mem_ready) begin
                  r_mem_valid <= 1'b0;
               end
               if (w_fire) begin
                  r_mem_pc         <= ex_pc;
                  r_mem_inst       <= ex_inst;
                  r_mem_rd_wr_addr <= ex_rd_wr_addr;
                  if (w_op == LSU_NONE) begin
                     r_mem_valid      <= 1'b1;
                     r_mem_ale        <= 1'b0;
                     r_mem_rd_wr_en   <= ex_rd_wr_en;
                     r_mem_rd_wr_data <= ex_result;
                  end else if (w_misal) begin
                     r_mem_valid      <= 1'b1;
                     r_mem_ale        <= 1'b1;
                     r_mem_rd_wr_en   <= 1'b0;
                     r_mem_rd_wr_data <= 32'd0;
                  end else begin
                     r_state          <= MA_REQ;
                     r_dmem_req       <= 1'b1;
                     r_dmem_we        <= w_store;
                     r_dmem_addr      <= {ex_result[31:2], 2'b00};
                     r_dmem_wdata     <= w_st_wdata;
                     r_dmem_wstrb     <= w_st_wstrb;
                     r_ld_op          <= w_op;
                     r_ld_lo          <= w_lo;
                     r_mem_ale        <= 1'b0;
                     r_mem_rd_wr_en   <= w_store ? 1'b0 : ex_rd_wr_en;
                     r_mem_rd_wr_data <= 32'd0;
                  end
               end
            end
            MA_REQ: begin
               if (dmem_gnt) begin
                  r_dmem_req   <= 1'b0;
                  r_dmem_we    <= 1'b0;
                  r_dmem_wdata <= 32'd0;
                  r_dmem_wstrb <= 4'b0000;
                  if (r_dmem_we) begin
                     r_state     <= MA_HOLD;
                     r_mem_valid <= 1'b1;
                  end else begin
                     r_state <= MA_WAIT;
                  end
               end
            end
            MA_WAIT: begin
               if (dmem_rvalid) begin
                  r_state          <= MA_HOLD;
                  r_mem_valid      <= 1'b1;
                  r_mem_rd_wr_data <= w_ld_data;
               end
            end
            MA_HOLD: begin
               if (r_mem_valid && mem_ready) begin
                  r_state     <= MA_IDLE;
                  r_mem_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= MA_IDLE;
            end
         endcase
      end
   end

   assign ex_ready       = w_ex_ready;
   assign dmem_req       = r_dmem_req;
   assign dmem_we        = r_dmem_we;
   assign dmem_addr      = r_dmem_addr;
   assign dmem_wdata     = r_dmem_wdata;
   assign dmem_wstrb     = r_dmem_wstrb;
   assign mem_valid      = r_mem_valid;
   assign mem_pc         = r_mem_pc;
   assign mem_inst       = r_mem_inst;
   assign mem_rd_wr_en   = r_mem_rd_wr_en;
   assign mem_rd_wr_addr = r_mem_rd_wr_addr;
   assign mem_rd_wr_data = r_mem_rd_wr_data;
   assign mem_ale        = r_mem_ale;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: directed ops push expected writeback bundles,
// a negedge monitor pops/compares on each accepted output and watches bus stability.
module tb_memory_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_pc, ex_inst, ex_result, ex_lsu_data;
   logic [3:0]  ex_lsu_op;
   logic        ex_rd_wr_en;
   logic [4:0]  ex_rd_wr_addr;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_pc, mem_inst, mem_rd_wr_data;
   logic        mem_rd_wr_en, mem_ale;
   logic [4:0]  mem_rd_wr_addr;

   always #5 clk = ~clk;

   memory_access #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_inst(ex_inst),
      .ex_result(ex_result), .ex_lsu_op(ex_lsu_op), .ex_lsu_data(ex_lsu_data),
      .ex_rd_wr_en(ex_rd_wr_en), .ex_rd_wr_addr(ex_rd_wr_addr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc), .mem_inst(mem_inst),
      .mem_rd_wr_en(mem_rd_wr_en), .mem_rd_wr_addr(mem_rd_wr_addr),
      .mem_rd_wr_data(mem_rd_wr_data), .mem_ale(mem_ale)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        chk_data;
      logic        rd_en;
      logic [4:0]  rd_addr;
      logic        ale;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Bus responder: grant after gnt_delay request cycles, rvalid rd_lat cycles after a load grant.
   int          gnt_delay = 0;
   int          rd_lat    = 1;
   int          req_cnt   = 0;
   int          rd_cnt    = 0;
   logic [31:0] bus_rdata = 32'd0;
   always begin
      @(posedge clk);
      #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = bus_rdata;
         end
      end
      if (dmem_req) begin
         if (req_cnt == gnt_delay) begin
            dmem_gnt = 1'b1;
            if (!dmem_we) rd_cnt = rd_lat;
         end
         req_cnt++;
      end else begin
         req_cnt = 0;
      end
   end

   // Bus monitor: request stability until grant, run length and captured request fields.
   int          req_seen = 0;
   int          cur_run  = 0;
   int          last_run = 0;
   logic        bp_req   = 1'b0, bp_gnt = 1'b0, bp_we = 1'b0;
   logic [31:0] bp_addr, bp_wdata;
   logic [3:0]  bp_wstrb;
   always @(negedge clk) begin
      if (rst) begin
         bp_req  = 1'b0;
         cur_run = 0;
      end else begin
         if (dmem_req) begin
            req_seen++;
            cur_run++;
            if (bp_req && !bp_gnt) begin
               check("req_stable_we", {31'd0, dmem_we}, {31'd0, bp_we});
               check("req_stable_addr", dmem_addr, bp_addr);
               check("req_stable_wdata", dmem_wdata, bp_wdata);
               check("req_stable_wstrb", {28'd0, dmem_wstrb}, {28'd0, bp_wstrb});
            end
            bp_we = dmem_we; bp_addr = dmem_addr; bp_wdata = dmem_wdata; bp_wstrb = dmem_wstrb;
         end else if (cur_run > 0) begin
            last_run = cur_run;
            cur_run  = 0;
         end
         bp_req = dmem_req;
         bp_gnt = dmem_gnt;
      end
   end

   // Output monitor: pops the scoreboard on accepted outputs, checks stability while stalled.
   logic        p_valid = 1'b0, p_ready = 1'b0, p_en = 1'b0, p_ale = 1'b0;
   logic [31:0] p_data, p_pc;
   always @(negedge clk) begin
      if (rst) begin
         p_valid = 1'b0;
      end else begin
         if (mem_valid && !mem_ready) check("ex_ready_in_stall", {31'd0, ex_ready}, 32'd0);
         if (p_valid && !p_ready) begin
            check("stall_valid", {31'd0, mem_valid}, 32'd1);
            check("stall_data", mem_rd_wr_data, p_data);
            check("stall_pc", mem_pc, p_pc);
            check("stall_en", {31'd0, mem_rd_wr_en}, {31'd0, p_en});
            check("stall_ale", {31'd0, mem_ale}, {31'd0, p_ale});
         end
         if (mem_valid && mem_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output_pc", mem_pc, 32'hFFFF_FFFF);
            end else begin
               e = sb_q.pop_front();
               check("out_pc", mem_pc, e.pc);
               check("out_rd_en", {31'd0, mem_rd_wr_en}, {31'd0, e.rd_en});
               check("out_rd_addr", {27'd0, mem_rd_wr_addr}, {27'd0, e.rd_addr});
               check("out_ale", {31'd0, mem_ale}, {31'd0, e.ale});
               if (e.chk_data) check("out_data", mem_rd_wr_data, e.data);
            end
         end
         p_valid = mem_valid; p_ready = mem_ready; p_data = mem_rd_wr_data;
         p_pc = mem_pc; p_en = mem_rd_wr_en; p_ale = mem_ale;
      end
   end

   task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [3:0] op,
                        input logic [31:0] sd, input logic [4:0] rda, input logic push,
                        input logic [31:0] xdata, input logic xchk, input logic xen,
                        input logic xale);
      exp_t x;
      int   n;
      logic done;
      x.pc = pc; x.data = xdata; x.chk_data = xchk; x.rd_en = xen; x.rd_addr = rda; x.ale = xale;
      if (push) sb_q.push_back(x);
      ex_pc = pc; ex_inst = pc ^ 32'h0000_0013; ex_result = res; ex_lsu_op = op;
      ex_lsu_data = sd; ex_rd_wr_en = 1'b1; ex_rd_wr_addr = rda; ex_valid = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 100) begin
         @(negedge clk);
         if (ex_ready) done = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      ex_valid = 1'b0;
      check("issue_accepted", {31'd0, done}, 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || mem_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check("drain_queue_empty", sb_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, r0;
      rst = 1'b1; ex_valid = 1'b0; ex_pc = 32'd0; ex_inst = 32'd0; ex_result = 32'd0;
      ex_lsu_op = 4'd0; ex_lsu_data = 32'd0; ex_rd_wr_en = 1'b0; ex_rd_wr_addr = 5'd0;
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
      check("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
      check("rst_data", mem_rd_wr_data, 32'd0);
      check("rst_ale", {31'd0, mem_ale}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", {31'd0, ex_ready}, 32'd1);
      @(posedge clk);
      #1;

      // ALU pass-through, latency and back-to-back throughput
      issue(32'h100, 32'h0000_1234, 4'd0, 32'd0, 5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b0);
      check("alu_valid_next_cycle", {31'd0, mem_valid}, 32'd1);
      check("alu_no_req", {31'd0, dmem_req}, 32'd0);
      c0 = cyc;
      issue(32'h104, 32'hAAAA_5555, 4'd0, 32'd0, 5'd6, 1'b1, 32'hAAAA_5555, 1'b1, 1'b1, 1'b0);
      issue(32'h108, 32'h0000_0001, 4'd0, 32'd0, 5'd7, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
      issue(32'h10C, 32'h0000_0077, 4'd12, 32'd0, 5'd8, 1'b1, 32'h0000_0077, 1'b1, 1'b1, 1'b0);
      check("alu_throughput_cycles", cyc - c0, 32'd3);
      drain();

      // Loads: lane extraction and extension
      bus_rdata = 32'h80FF_FF7F;
      issue(32'h200, 32'h0000_1003, 4'd1, 32'd0, 5'd9, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0);
      drain();
      check("ldb_word_addr", bp_addr, 32'h0000_1000);
      issue(32'h204, 32'h0000_1003, 4'd4, 32'd0, 5'd9, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b0);
      issue(32'h208, 32'h0000_1002, 4'd2, 32'd0, 5'd10, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b1, 1'b0);
      issue(32'h20C, 32'h0000_1000, 4'd5, 32'd0, 5'd11, 1'b1, 32'h0000_FF7F, 1'b1, 1'b1, 1'b0);
      issue(32'h210, 32'h0000_1000, 4'd1, 32'd0, 5'd12, 1'b1, 32'h0000_007F, 1'b1, 1'b1, 1'b0);
      drain();
      bus_rdata = 32'h1234_5678;
      issue(32'h214, 32'h0000_1004, 4'd3, 32'd0, 5'd13, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
      drain();

      // Stores: lane placement and request stability under delayed grant
      gnt_delay = 3;
      issue(32'h300, 32'h0000_2002, 4'd7, 32'h0000_ABCD, 5'd1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      drain();
      check("sth_wstrb", {28'd0, bp_wstrb}, 32'h0000_000C);
      check("sth_wdata", bp_wdata, 32'hABCD_ABCD);
      check("sth_addr", bp_addr, 32'h0000_2000);
      check("sth_we", {31'd0, bp_we}, 32'd1);
      check("sth_req_cycles", last_run, 32'd4);
      gnt_delay = 0;
      issue(32'h304, 32'h0000_2001, 4'd6, 32'h1234_5678, 5'd2, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      drain();
      check("stb_wstrb", {28'd0, bp_wstrb}, 32'h0000_0002);
      check("stb_wdata", bp_wdata, 32'h7878_7878);
      check("stb_req_cycles", last_run, 32'd1);
      issue(32'h308, 32'h0000_2004, 4'd8, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      drain();
      check("stw_wstrb", {28'd0, bp_wstrb}, 32'h0000_000F);
      check("stw_wdata", bp_wdata, 32'hDEAD_BEEF);
      check("stw_addr", bp_addr, 32'h0000_2004);

      // Misaligned accesses raise ale without touching the bus
      r0 = req_seen;
      issue(32'h400, 32'h0000_3001, 4'd3, 32'd0, 5'd4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
      issue(32'h404, 32'h0000_3003, 4'd7, 32'h55, 5'd4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
      issue(32'h408, 32'h0000_3001, 4'd5, 32'd0, 5'd4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
      drain();
      check("misaligned_no_req", req_seen - r0, 32'd0);

      // Load completing into a stalled writeback stage
      mem_ready = 1'b0;
      bus_rdata = 32'hCAFE_F00D;
      issue(32'h500, 32'h0000_4000, 4'd3, 32'd0, 5'd14, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0);
      c0 = 0;
      while (!mem_valid && c0 < 50) begin
         @(negedge clk);
         c0++;
      end
      check("stall_load_completed", {31'd0, mem_valid}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("stall_ex_ready_low", {31'd0, ex_ready}, 32'd0);
      end
      @(posedge clk);
      #1 mem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold_to_idle_valid", {31'd0, mem_valid}, 32'd0);
      check("hold_to_idle_ready", {31'd0, ex_ready}, 32'd1);
      drain();

      // Reset during WAIT; the late rvalid must not produce an output
      rd_lat = 4;
      bus_rdata = 32'h1111_1111;
      issue(32'h600, 32'h0000_5000, 4'd3, 32'd0, 5'd15, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("wait_no_req", {31'd0, dmem_req}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_dmem_addr", dmem_addr, 32'd0);
      check("midrst_mem_pc", mem_pc, 32'd0);
      check("midrst_rd_en", {31'd0, mem_rd_wr_en}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("no_valid_after_rst", {31'd0, mem_valid}, 32'd0);
         check("no_req_after_rst", {31'd0, dmem_req}, 32'd0);
      end
      rd_lat = 1;
      @(posedge clk);
      #1;
      issue(32'h700, 32'h0000_0042, 4'd0, 32'd0, 5'd16, 1'b1, 32'h0000_0042, 1'b1, 1'b1, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
